// File: rtl/can_rx_apb_pkg.sv
// Shared types and constants for the CAN receive APB register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package can_pkg;

    // Register byte offsets within the 32-byte window
    localparam logic [4:0] ADDR_RXHI = 5'h00;
    localparam logic [4:0] ADDR_RXLO = 5'h04;
    localparam logic [4:0] ADDR_CFG  = 5'h08;
    localparam logic [4:0] ADDR_RXID = 5'h0C;
    localparam logic [4:0] ADDR_STAT = 5'h10;

    // Value driven on PRDATA whenever no read access phase is in progress
    localparam logic [31:0] IDLE_RDATA = 32'h1213_1415;

    // Writable bits of CFG; reserved bits always read back as zero
    localparam logic [31:0] CFG_MASK = 32'hFFFF_F001;

    typedef struct packed {
        logic [7:0]  quantaDiv;
        logic [5:0]  propQuanta;
        logic [5:0]  seg1Quanta;
        logic [10:0] rsvd;
        logic        rx_enable;
    } cfgT;

    typedef struct packed {
        logic [28:0] id;
        logic        format;
        logic [1:0]  frameType;
        logic [3:0]  datalen;
        logic [63:0] data;
    } rxFrameT;

endpackage

// File: rtl/can_rx_fifo.sv
// Frame FIFO holding completed receive frames until software pops them.
// Latency: push visible at head one cycle later; head is a combinational read of storage.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and flagged.
module can_rx_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  rxFrameT       wdat,
    output rxFrameT       head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    rxFrameT       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Frame storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdat;
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/can_rx_apb.sv
// APB register block for the CAN receiver: bit-timing config, frame FIFO readout, irq.
// Latency: reads combinational, writes on the access-phase edge, irq one cycle behind status.
// Backpressure: none; frames arriving when the FIFO is full are dropped and overflow is set.
module can_rx_apb
    import can_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    input  logic        rx_valid,
    input  logic        rx_crcerr,
    input  logic [28:0] rx_id,
    input  logic        rx_format,
    input  logic [1:0]  rx_frameType,
    input  logic [3:0]  rx_datalen,
    input  logic [63:0] rx_data,
    output logic [7:0]  quantaDiv,
    output logic [5:0]  propQuanta,
    output logic [5:0]  seg1Quanta,
    output logic        rx_enable,
    output logic        irq
);

    cfgT           cfg;
    logic          overflow;
    logic [7:0]    errcnt;
    rxFrameT       wframe;
    rxFrameT       head;
    logic [CW-1:0] count;
    logic [4:0]    count5;
    logic          full;
    logic          empty;
    logic          drop;
    logic          wr_en;
    logic          rd_en;
    logic          stat_wr;
    logic          pop;
    logic          rx_push;
    logic          rx_err;
    logic [31:0]   rdata;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & PENABLE & ~PWRITE;
    assign stat_wr = wr_en & (PADDR == ADDR_STAT);
    assign pop     = stat_wr & PWDATA[0];
    assign rx_push = rx_valid & cfg.rx_enable & ~rx_crcerr;
    assign rx_err  = rx_valid & cfg.rx_enable & rx_crcerr;
    assign wframe  = '{id: rx_id, format: rx_format, frameType: rx_frameType,
                       datalen: rx_datalen, data: rx_data};
    assign count5  = 5'(count);

    assign quantaDiv  = cfg.quantaDiv;
    assign propQuanta = cfg.propQuanta;
    assign seg1Quanta = cfg.seg1Quanta;
    assign rx_enable  = cfg.rx_enable;

    can_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (rx_push),
        .pop   (pop),
        .wdat  (wframe),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    // CFG register; reserved bits are masked off on write
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            cfg <= '0;
        else if (wr_en && (PADDR == ADDR_CFG))
            cfg <= cfgT'(PWDATA & CFG_MASK);
    end

    // Sticky overflow and saturating CRC-error counter; a new overflow beats a clear, an errcnt clear beats an increment
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            overflow <= 1'b0;
            errcnt   <= '0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (stat_wr && PWDATA[2])
                overflow <= 1'b0;
            if (stat_wr && PWDATA[8])
                errcnt <= '0;
            else if (rx_err && (errcnt != 8'hFF))
                errcnt <= errcnt + 8'd1;
        end
    end

    // Interrupt registered from current status, so it trails the status bits by one cycle
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) irq <= 1'b0;
        else        irq <= cfg.rx_enable & (~empty | overflow);
    end

    // Register read decode; unmapped offsets read zero
    always_comb begin
        rdata = '0;
        case (PADDR)
            ADDR_RXHI: rdata = head.data[63:32];
            ADDR_RXLO: rdata = head.data[31:0];
            ADDR_CFG:  rdata = cfg;
            ADDR_RXID: rdata = {head.id, 3'b000};
            ADDR_STAT: rdata = {head.datalen, head.format, head.frameType, 9'b0,
                                errcnt, count5, overflow, full, ~empty};
            default:   rdata = '0;
        endcase
    end

    assign PRDATA = rd_en ? rdata : IDLE_RDATA;

endmodule

// File: tb/tb_can_rx_apb.sv
// Bench for can_rx_apb: directed register scenarios plus random traffic against a queue model.
module tb_can_rx_apb;
    import can_pkg::*;

    localparam int DEPTH = 4;

    logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        rx_valid, rx_crcerr, rx_format;
    logic [28:0] rx_id;
    logic [1:0]  rx_frameType;
    logic [3:0]  rx_datalen;
    logic [63:0] rx_data;
    logic [7:0]  quantaDiv;
    logic [5:0]  propQuanta, seg1Quanta;
    logic        rx_enable, irq;

    int vectors = 0;
    int fails   = 0;
    bit rnd_rx  = 0;

    can_rx_apb #(.DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .rx_valid(rx_valid), .rx_crcerr(rx_crcerr), .rx_id(rx_id),
        .rx_format(rx_format), .rx_frameType(rx_frameType),
        .rx_datalen(rx_datalen), .rx_data(rx_data),
        .quantaDiv(quantaDiv), .propQuanta(propQuanta), .seg1Quanta(seg1Quanta),
        .rx_enable(rx_enable), .irq(irq)
    );

    initial PCLK = 0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    rxFrameT     q[$];
    logic [31:0] cfg_m;
    bit          ovf_m;
    int          err_m;
    bit          irq_m;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        rxFrameT h;
        int n;
        n = q.size();
        h = (n == 0) ? '0 : q[0];
        case (a)
            5'h00: return h.data[63:32];
            5'h04: return h.data[31:0];
            5'h08: return cfg_m;
            5'h0C: return {h.id, 3'b000};
            5'h10: return {h.datalen, h.format, h.frameType, 9'b0, err_m[7:0],
                           5'(n), ovf_m, (n == DEPTH), (n != 0)};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            q.delete();
            cfg_m = 0; ovf_m = 0; err_m = 0; irq_m = 0;
        end else begin
            bit en, wr, popreq, popped, set, stat;
            int n;
            rxFrameT f;
            en     = cfg_m[0];
            irq_m  = en && (q.size() != 0 || ovf_m);
            wr     = PSEL && PENABLE && PWRITE;
            stat   = wr && (PADDR == 5'h10);
            popreq = stat && PWDATA[0];
            n      = q.size();
            popped = popreq && n > 0;
            set    = 0;
            if (popped) void'(q.pop_front());
            if (rx_valid && en && !rx_crcerr) begin
                f = '{id: rx_id, format: rx_format, frameType: rx_frameType,
                      datalen: rx_datalen, data: rx_data};
                if (n < DEPTH || popped) q.push_back(f);
                else set = 1;
            end
            if (set) ovf_m = 1;
            else if (stat && PWDATA[2]) ovf_m = 0;
            if (stat && PWDATA[8]) err_m = 0;
            else if (rx_valid && en && rx_crcerr && err_m < 255) err_m++;
            if (wr && PADDR == 5'h08) cfg_m = PWDATA & 32'hFFFF_F001;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge PCLK) begin
        check("quantaDiv",  32'(quantaDiv),  32'(cfg_m[31:24]));
        check("propQuanta", 32'(propQuanta), 32'(cfg_m[23:18]));
        check("seg1Quanta", 32'(seg1Quanta), 32'(cfg_m[17:12]));
        check("rx_enable",  32'(rx_enable),  32'(cfg_m[0]));
        check("irq",        32'(irq),        32'(irq_m));
        check("PRDATA", PRDATA,
              (PSEL && PENABLE && !PWRITE) ? model_read(PADDR) : 32'h1213_1415);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        tick(); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        tick(); PENABLE = 1;
        tick(); PSEL = 0; PENABLE = 0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        tick(); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        tick(); PENABLE = 1;
        @(negedge PCLK); d = PRDATA;
        tick(); PSEL = 0; PENABLE = 0;
    endtask

    task automatic set_rx(input logic [28:0] id, input logic [3:0] dl,
                          input logic [63:0] d, input logic crc);
        rx_valid = 1; rx_crcerr = crc; rx_id = id; rx_format = 0;
        rx_frameType = 0; rx_datalen = dl; rx_data = d;
    endtask

    task automatic send_rx(input logic [28:0] id, input logic [3:0] dl,
                           input logic [63:0] d, input logic crc);
        tick(); set_rx(id, dl, d, crc);
        tick(); rx_valid = 0; rx_crcerr = 0;
    endtask

    // Random receive traffic, active only during the random phase
    always begin
        @(posedge PCLK); #1;
        if (rnd_rx) begin
            rx_valid     = ($urandom_range(0, 2) == 0);
            rx_crcerr    = ($urandom_range(0, 4) == 0);
            rx_id        = 29'($urandom);
            rx_format    = 1'($urandom);
            rx_frameType = 2'($urandom);
            rx_datalen   = 4'($urandom);
            rx_data      = {$urandom, $urandom};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [31:0] rd;

    initial begin
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        rx_valid = 0; rx_crcerr = 0; rx_id = 0; rx_format = 0; rx_frameType = 0;
        rx_datalen = 0; rx_data = 0;
        #12 PRESET = 0;

        // Reset state and CFG masking
        apb_read(5'h08, rd);            check("cfg_reset", rd, 32'h0);
        apb_read(5'h10, rd);            check("stat_reset", rd, 32'h0);
        apb_write(5'h08, 32'h10C3_0FFF);
        apb_read(5'h08, rd);            check("cfg_readback", rd, 32'h10C3_0001);
        check("cfg_qdiv", 32'(quantaDiv), 32'h10);
        check("cfg_en", 32'(rx_enable), 32'h1);

        // Single frame round trip
        send_rx(29'h1ABCDEF, 4'd8, 64'h0123_4567_89AB_CDEF, 0);
        apb_read(5'h10, rd);            check("stat_one", rd, 32'h8000_0009);
        check("irq_one", 32'(irq), 32'h1);
        apb_read(5'h00, rd);            check("rxhi", rd, 32'h0123_4567);
        apb_read(5'h04, rd);            check("rxlo", rd, 32'h89AB_CDEF);
        apb_read(5'h0C, rd);            check("rxid", rd, 32'h0D5E_6F78);
        apb_write(5'h10, 32'h1);
        apb_read(5'h10, rd);            check("stat_popped", rd, 32'h0);
        check("irq_popped", 32'(irq), 32'h0);

        // Overflow: five pushes into a four-deep FIFO
        for (int k = 1; k <= 5; k++) send_rx(29'(k), 4'd0, {32'hA5A5_A5A5, 32'(k)}, 0);
        apb_read(5'h10, rd);            check("stat_full_ovf", {24'h0, rd[7:0]}, 32'h27);
        for (int k = 1; k <= 4; k++) begin
            apb_read(5'h04, rd);        check("fifo_order", rd, 32'(k));
            apb_write(5'h10, 32'h1);
        end
        apb_write(5'h10, 32'h4);
        apb_read(5'h10, rd);            check("ovf_cleared", rd, 32'h0);

        // Full FIFO with push and pop in the same cycle
        for (int k = 11; k <= 14; k++) send_rx(29'(k), 4'd0, 64'(k), 0);
        tick(); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 5'h10; PWDATA = 32'h1;
        tick(); PENABLE = 1; set_rx(29'd15, 4'd0, 64'd15, 0);
        tick(); PSEL = 0; PENABLE = 0; rx_valid = 0;
        apb_read(5'h10, rd);            check("full_pushpop", {24'h0, rd[7:0]}, 32'h23);
        for (int k = 0; k < 3; k++) apb_write(5'h10, 32'h1);
        apb_read(5'h04, rd);            check("tail_is_new", rd, 32'd15);
        apb_write(5'h10, 32'h1);

        // CRC errors, disabled receiver, errcnt clear
        for (int k = 0; k < 3; k++) send_rx(29'h5, 4'd1, 64'h1, 1);
        apb_read(5'h10, rd);            check("errcnt3", rd, 32'h0000_0300);
        apb_write(5'h08, 32'h10C3_0000);
        send_rx(29'h6, 4'd1, 64'h2, 0);
        send_rx(29'h7, 4'd1, 64'h3, 1);
        apb_read(5'h10, rd);            check("disabled_rx", rd, 32'h0000_0300);
        apb_write(5'h08, 32'h10C3_0001);
        apb_write(5'h10, 32'h100);
        apb_read(5'h10, rd);            check("errcnt_clr", rd, 32'h0);

        // Asynchronous reset between edges with frames queued
        send_rx(29'h21, 4'd2, 64'h21, 0);
        send_rx(29'h22, 4'd2, 64'h22, 0);
        @(posedge PCLK); #3 PRESET = 1;
        #1;
        check("arst_qdiv", 32'(quantaDiv), 32'h0);
        check("arst_en", 32'(rx_enable), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 5'h10;
        #1 check("arst_stat", PRDATA, 32'h0);
        PADDR = 5'h08;
        #1 check("arst_cfg", PRDATA, 32'h0);
        PSEL = 0; PENABLE = 0;
        #1 check("idle_prdata", PRDATA, 32'h1213_1415);
        @(negedge PCLK); PRESET = 0;

        // Random phase
        apb_write(5'h08, 32'h4A12_3001);
        rnd_rx = 1;
        repeat (400) begin
            case ($urandom_range(0, 9))
                0: apb_write(5'h08, $urandom | 32'(($urandom_range(0, 4) != 0)));
                1, 2, 3: apb_read(5'($urandom), rd);
                4, 5, 6: apb_write(5'h10, $urandom & 32'h105);
                7: apb_write(5'($urandom), $urandom);
                default: tick();
            endcase
        end
        rnd_rx = 0;
        tick(); rx_valid = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
